// File: rtl/execute_memory_register.sv
// Execute-to-memory pipeline register with stall and flush handling.
// It also holds the MADD/MSUB scratch state (partial product and cycle count) so execute can read it back across a stall.
module execute_memory_register (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  execute_dest_addr,
    input  logic        execute_write_or_not,
    input  logic [31:0] execute_wdata,
    input  logic        execute_HILO_enabler,
    input  logic [31:0] execute_HILO_HI,
    input  logic [31:0] execute_HILO_LO,
    input  logic [63:0] execute_hilo_temp,
    input  logic [1:0]  execute_cnt,
    output logic [4:0]  dest_addr,
    output logic        write_or_not,
    output logic [31:0] wdata,
    output logic        execute2memory_HILO_enabler,
    output logic [31:0] execute2memory_HILO_HI,
    output logic [31:0] execute2memory_HILO_LO,
    output logic [63:0] hilo_temp_output,
    output logic [1:0]  cnt_output
);

    logic [4:0]  dest_addr_reg;
    logic        write_or_not_reg;
    logic [31:0] wdata_reg;
    logic        hilo_en_reg;
    logic [31:0] hilo_hi_reg;
    logic [31:0] hilo_lo_reg;
    logic [63:0] hilo_temp_reg;
    logic [1:0]  cnt_reg;

    logic execute_stalled;
    logic memory_stalled;

    assign execute_stalled = stall[3];
    assign memory_stalled  = stall[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            dest_addr_reg    <= '0;
            write_or_not_reg <= 1'b0;
            wdata_reg        <= '0;
            hilo_en_reg      <= 1'b0;
            hilo_hi_reg      <= '0;
            hilo_lo_reg      <= '0;
            hilo_temp_reg    <= '0;
            cnt_reg          <= '0;
        end else if (memory_stalled) begin
            // Memory is frozen: every field, scratch included, holds.
            dest_addr_reg    <= dest_addr_reg;
            write_or_not_reg <= write_or_not_reg;
            wdata_reg        <= wdata_reg;
            hilo_en_reg      <= hilo_en_reg;
            hilo_hi_reg      <= hilo_hi_reg;
            hilo_lo_reg      <= hilo_lo_reg;
            hilo_temp_reg    <= hilo_temp_reg;
            cnt_reg          <= cnt_reg;
        end else if (execute_stalled) begin
            // Bubble into memory while execute's multi-cycle scratch state is parked here.
            dest_addr_reg    <= '0;
            write_or_not_reg <= 1'b0;
            wdata_reg        <= '0;
            hilo_en_reg      <= 1'b0;
            hilo_hi_reg      <= '0;
            hilo_lo_reg      <= '0;
            hilo_temp_reg    <= execute_hilo_temp;
            cnt_reg          <= execute_cnt;
        end else begin
            dest_addr_reg    <= execute_dest_addr;
            write_or_not_reg <= execute_write_or_not;
            wdata_reg        <= execute_wdata;
            hilo_en_reg      <= execute_HILO_enabler;
            hilo_hi_reg      <= execute_HILO_HI;
            hilo_lo_reg      <= execute_HILO_LO;
            hilo_temp_reg    <= '0;
            cnt_reg          <= '0;
        end
    end

    assign dest_addr                   = dest_addr_reg;
    assign write_or_not                = write_or_not_reg;
    assign wdata                       = wdata_reg;
    assign execute2memory_HILO_enabler = hilo_en_reg;
    assign execute2memory_HILO_HI      = hilo_hi_reg;
    assign execute2memory_HILO_LO      = hilo_lo_reg;
    assign hilo_temp_output            = hilo_temp_reg;
    assign cnt_output                  = cnt_reg;

endmodule

// File: tb/tb_execute_memory_register.sv
// Directed bench for execute_memory_register: a per-cycle model comparison plus literal checks on key scenarios.
module tb_execute_memory_register;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  execute_dest_addr;
    logic        execute_write_or_not;
    logic [31:0] execute_wdata;
    logic        execute_HILO_enabler;
    logic [31:0] execute_HILO_HI;
    logic [31:0] execute_HILO_LO;
    logic [63:0] execute_hilo_temp;
    logic [1:0]  execute_cnt;
    logic [4:0]  dest_addr;
    logic        write_or_not;
    logic [31:0] wdata;
    logic        execute2memory_HILO_enabler;
    logic [31:0] execute2memory_HILO_HI;
    logic [31:0] execute2memory_HILO_LO;
    logic [63:0] hilo_temp_output;
    logic [1:0]  cnt_output;

    int checks = 0;
    int errors = 0;

    execute_memory_register dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .execute_dest_addr(execute_dest_addr),
        .execute_write_or_not(execute_write_or_not),
        .execute_wdata(execute_wdata),
        .execute_HILO_enabler(execute_HILO_enabler),
        .execute_HILO_HI(execute_HILO_HI),
        .execute_HILO_LO(execute_HILO_LO),
        .execute_hilo_temp(execute_hilo_temp),
        .execute_cnt(execute_cnt),
        .dest_addr(dest_addr),
        .write_or_not(write_or_not),
        .wdata(wdata),
        .execute2memory_HILO_enabler(execute2memory_HILO_enabler),
        .execute2memory_HILO_HI(execute2memory_HILO_HI),
        .execute2memory_HILO_LO(execute2memory_HILO_LO),
        .hilo_temp_output(hilo_temp_output),
        .cnt_output(cnt_output)
    );

    always #5 clk = ~clk;

    // Model state: what memory sees and what execute reads back.
    typedef struct packed {
        logic [4:0]  dest;
        logic        wr;
        logic [31:0] data;
        logic        hen;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] temp;
        logic [1:0]  cnt;
    } view_t;

    view_t model = '0;
    view_t seen;

    always @(posedge clk or posedge rst) begin
        view_t incoming;
        incoming = '{execute_dest_addr, execute_write_or_not, execute_wdata,
                     execute_HILO_enabler, execute_HILO_HI, execute_HILO_LO,
                     64'd0, 2'd0};
        if (rst || flush)
            model = '0;
        else if (stall[4])
            model = model;
        else if (stall[3])
            model = '{5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, execute_hilo_temp, execute_cnt};
        else
            model = incoming;
    end

    assign seen = '{dest_addr, write_or_not, wdata, execute2memory_HILO_enabler,
                    execute2memory_HILO_HI, execute2memory_HILO_LO,
                    hilo_temp_output, cnt_output};

    always @(negedge clk) begin
        checks++;
        if (seen !== model) begin
            errors++;
            $display("FAIL cycle_model t=%0t got=%h want=%h", $time, seen, model);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end else
            $display("ok   %s = %h", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [5:0] st, input logic fl, input logic [4:0] d,
                         input logic w, input logic [31:0] wd, input logic he,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic [63:0] tmp, input logic [1:0] c);
        stall = st; flush = fl; execute_dest_addr = d; execute_write_or_not = w;
        execute_wdata = wd; execute_HILO_enabler = he; execute_HILO_HI = hi;
        execute_HILO_LO = lo; execute_hilo_temp = tmp; execute_cnt = c;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {hilo_temp_output}, 64'd0);
        chk(name, {dest_addr, write_or_not, wdata, execute2memory_HILO_enabler, cnt_output}, 64'd0);
        chk(name, {execute2memory_HILO_HI, execute2memory_HILO_LO}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 64'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;

        // Normal capture; scratch inputs non-zero must still clear.
        drive(6'd0, 1'b0, 5'd9, 1'b1, 32'hDEADBEEF, 1'b1, 32'h1, 32'h2, 64'hFFFF, 2'd3);
        step();
        chk("normal_dest", dest_addr, 64'd9);
        chk("normal_wdata", wdata, 64'hDEADBEEF);
        chk("normal_wr_hen", {write_or_not, execute2memory_HILO_enabler}, 64'h3);
        chk("normal_hilo", {execute2memory_HILO_HI, execute2memory_HILO_LO}, 64'h0000_0001_0000_0002);
        chk("normal_scratch", {hilo_temp_output, cnt_output}, 64'd0);

        // MADD cycle 1: bubble with scratch.
        drive(6'b001111, 1'b0, 5'd7, 1'b1, 32'h55, 1'b1, 32'h9, 32'h8, 64'h0000_0001_0000_0002, 2'd1);
        step();
        chk("bubble_wr_data_hen", {write_or_not, wdata, execute2memory_HILO_enabler}, 64'd0);
        chk("bubble_temp", hilo_temp_output, 64'h0000_0001_0000_0002);
        chk("bubble_cnt", cnt_output, 64'd1);

        // Back-to-back bubble: scratch tracks execute.
        drive(6'b001111, 1'b0, 5'd7, 1'b1, 32'h66, 1'b1, 32'h9, 32'h8, 64'h1234_5678_9ABC_DEF0, 2'd2);
        step();
        chk("bubble2_temp", hilo_temp_output, 64'h1234_5678_9ABC_DEF0);
        chk("bubble2_dest_wdata", {dest_addr, wdata}, 64'd0);

        // MADD cycle 2: normal capture, scratch clears.
        drive(6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h3, 32'h4, 64'hAAAA, 2'd2);
        step();
        chk("madd_hilo", {execute2memory_HILO_HI, execute2memory_HILO_LO}, 64'h0000_0003_0000_0004);
        chk("madd_hen", execute2memory_HILO_enabler, 64'd1);
        chk("madd_scratch", {hilo_temp_output, cnt_output}, 64'd0);

        // Memory stall hold for 3 edges with changing inputs.
        drive(6'd0, 1'b0, 5'd3, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h11, 32'h22, 64'd0, 2'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(6'b011111, 1'b0, 5'(i + 20), 1'b0, 32'h100 + 32'(i), 1'b1, 32'(i), 32'(i),
                  64'(i + 1), 2'(i + 1));
            step();
            chk("hold_wdata", wdata, 64'hA5A5A5A5);
            chk("hold_dest_wr", {dest_addr, write_or_not}, 64'h7);
        end

        // Memory stall with execute not stalled still holds scratch from a bubble.
        drive(6'b001000, 1'b0, 5'd1, 1'b1, 32'h77, 1'b1, 32'h5, 32'h6, 64'hBEEF, 2'd1);
        step();
        drive(6'b010000, 1'b0, 5'd2, 1'b1, 32'h88, 1'b1, 32'h5, 32'h6, 64'hCAFE, 2'd3);
        step();
        chk("hold_scratch", {hilo_temp_output, cnt_output}, {62'hBEEF, 2'd1} );
        // Release: next edge is normal.
        drive(6'd0, 1'b0, 5'd12, 1'b1, 32'h12345678, 1'b0, 32'h0, 32'h0, 64'h1, 2'd1);
        step();
        chk("release_wdata", wdata, 64'h12345678);

        // Flush wins over memory stall.
        drive(6'b011111, 1'b1, 5'd4, 1'b1, 32'h99, 1'b1, 32'h1, 32'h1, 64'h5, 2'd1);
        step();
        chk_all_zero("flush_over_stall");

        // Flush during a MADD bubble clears the counter.
        drive(6'b001111, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 64'h77, 2'd1);
        step();
        chk("pre_flush_cnt", cnt_output, 64'd1);
        drive(6'b001111, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 64'h78, 2'd2);
        step();
        chk("flush_bubble_scratch", {hilo_temp_output, cnt_output}, 64'd0);

        // Async reset mid-MADD, mid-cycle.
        drive(6'b001111, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 64'h4242, 2'd1);
        step();
        chk("pre_reset_cnt", cnt_output, 64'd1);
        drive(6'd0, 1'b0, 5'd30, 1'b1, 32'hFEEDFACE, 1'b1, 32'h7, 32'h8, 64'd0, 2'd0);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        step();
        chk_all_zero("reset_held");
        #1 rst = 1'b0;
        step();
        chk("post_reset_wdata", wdata, 64'hFEEDFACE);
        chk("post_reset_dest", dest_addr, 64'd30);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_memory_register.md
# execute_memory_register

Pipeline register between the execute stage and the memory stage of the five-stage MIPS core. Captures the execute stage's writeback destination, write enable, result data and HI/LO update on each rising clock edge and presents them to the memory stage. It honours the global stall vector and flush, inserts bubbles when execute stalls but memory does not, and carries the two-cycle MADD/MADDU/MSUB/MSUBU scratch state (64-bit partial product plus cycle counter) back to the execute stage across a stall.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  6  global stall vector; bit 3 = execute stalled, bit 4 = memory stalled; bits 0-2 and 5 ignored
- flush  in  1  exception/branch flush; squashes this register on the next edge
- execute_dest_addr  in  5  GPR writeback address from execute
- execute_write_or_not  in  1  GPR write enable from execute
- execute_wdata  in  32  GPR write data from execute
- execute_HILO_enabler  in  1  HI/LO write enable from execute
- execute_HILO_HI  in  32  HI value from execute
- execute_HILO_LO  in  32  LO value from execute
- execute_hilo_temp  in  64  MADD/MSUB partial product from execute
- execute_cnt  in  2  MADD/MSUB cycle counter from execute
- dest_addr  out  5  registered GPR address to memory stage
- write_or_not  out  1  registered GPR write enable to memory stage
- wdata  out  32  registered GPR data to memory stage
- execute2memory_HILO_enabler  out  1  registered HI/LO write enable
- execute2memory_HILO_HI  out  32  registered HI
- execute2memory_HILO_LO  out  32  registered LO
- hilo_temp_output  out  64  partial product fed back to execute
- cnt_output  out  2  cycle counter fed back to execute

## Operation
- All outputs are flops; no combinational path from any input to any output.
- Update priority at each rising clk edge:
  1. flush = 1: all outputs to 0, including hilo_temp_output and cnt_output.
  2. stall[4] = 1: hold every output unchanged, regardless of stall[3].
  3. stall[3] = 1, stall[4] = 0 (bubble): the six pipeline outputs go to 0; hilo_temp_output <= execute_hilo_temp and cnt_output <= execute_cnt.
  4. stall[3] = 0 (normal): the six pipeline outputs capture their execute_* inputs; hilo_temp_output and cnt_output go to 0.
- A bubble has write_or_not = 0 and execute2memory_HILO_enabler = 0, so memory and writeback perform no architectural update.
- MADD sequence: in cycle 1, execute asserts the stall request and drives cnt = 1 with the partial product. The stall controller drives stall[3] = 1, stall[4] = 0, and this block latches the scratch state. In cycle 2, execute reads hilo_temp_output/cnt_output, finishes, and drives cnt = 2 with stall released. The result is captured normally and the scratch state clears.
- Fields are stored bit-exact with no arithmetic; widths match port-to-port.

## Timing
- Latency: exactly 1 cycle from execute_* input to output under normal capture.
- Reset: while rst = 1, every output is 0 immediately, without waiting for clk. The first capture occurs at the first rising edge after rst deasserts.
- Reset mid-MADD: scratch state is lost and cnt_output = 0. Execute restarts the instruction.
- flush coincident with any stall pattern: flush wins and all outputs are 0 on that edge.
- flush during a MADD bubble clears cnt_output, so execute restarts any re-fetched MADD from cycle 1.
- Back-to-back stalls (stall[3] = 1 and stall[4] = 0 for N edges): pipeline outputs stay 0 and scratch state tracks execute every edge.
- After a memory stall releases (stall[4] 1 -> 0), the next edge follows rules 3 or 4 using the current inputs.

## Test plan
- Reset: assert rst asynchronously mid-cycle with outputs non-zero -> all outputs read 0 before the next clk edge and stay 0 until the first edge after release.
- Normal capture: stall = 0, dest 5'd9, wdata 32'hDEADBEEF, write 1, HILO_en 1, HI 32'h1, LO 32'h2 -> exactly those values appear one edge later; hilo_temp_output = 0 and cnt_output = 0.
- Bubble with scratch: stall = 6'b001111, execute_hilo_temp 64'h0000_0001_0000_0002, cnt 2'd1, wdata 32'h55 -> write_or_not = 0, wdata = 0, HILO_enabler = 0, hilo_temp_output = 64'h0000_0001_0000_0002, cnt_output = 1.
- Memory stall hold: load wdata 32'hA5A5A5A5, then stall = 6'b011111 for 3 edges while the inputs change -> outputs remain 32'hA5A5A5A5 with their other captured fields for all 3 edges.
- Flush priority: flush = 1 with stall = 6'b011111 and outputs non-zero -> all outputs 0 after one edge, including cnt_output.
- Full MADD: cycle 1 as in the bubble case, cycle 2 with stall = 0, HI 32'h3, LO 32'h4, HILO_en 1 -> outputs carry HI 3 and LO 4, and hilo_temp_output and cnt_output return to 0.
